// File: rtl/cpu_acc_ctrl.sv
`timescale 1ns/1ps
// Purpose : sequence asynchronous host CPU register accesses onto NSLV internal register slaves.
// Latency : slv_ce on the 3rd clk edge after pce_ falls; prdy 1 cycle after slave ready, or after TOMAX+1 cycles (timeout).
// Backpr. : CPU is held off by prdy; prdy/perr/pdo stay stable until pce_ is released, and no new access starts before then.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_pce_, i_pwr       CPU chip enable (active low, async to clk), write=1/read=0
//   i_paddr, i_pdi      CPU address (upper SELW bits select the slave), write data
//   o_pdo, o_prdy       read data and stretched ready back to the CPU
//   o_perr              decode miss or timeout, valid while o_prdy=1
//   o_slv_ce, o_slv_wr  one-hot slave chip enable, write qualifier
//   o_slv_addr/_wdat    latched slave address and write data
//   i_slv_rdat/_rdy     packed slave read data (slave i at [i*DW +: DW]) and per-slave ready
module cpu_acc_ctrl #(
    parameter int NSLV  = 4,
    parameter int SELW  = 2,
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int TOW   = 8,
    parameter int TOMAX = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pce_,
    input  logic                 i_pwr,
    input  logic [SELW+AW-1:0]   i_paddr,
    input  logic [DW-1:0]        i_pdi,
    output logic [DW-1:0]        o_pdo,
    output logic                 o_prdy,
    output logic                 o_perr,
    output logic [NSLV-1:0]      o_slv_ce,
    output logic                 o_slv_wr,
    output logic [AW-1:0]        o_slv_addr,
    output logic [DW-1:0]        o_slv_wdat,
    input  logic [NSLV*DW-1:0]   i_slv_rdat,
    input  logic [NSLV-1:0]      i_slv_rdy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;

    // pce_ synchroniser plus one delayed copy for falling-edge detection
    logic                r_pce_meta;
    logic                r_pce_s;
    logic                r_pce_s_prev;

    logic [SELW-1:0]     r_sel,      w_sel_nxt;
    logic [TOW-1:0]      r_timer,    w_timer_nxt;
    logic                r_prdy,     w_prdy_nxt;
    logic                r_perr,     w_perr_nxt;
    logic [DW-1:0]       r_pdo,      w_pdo_nxt;
    logic [NSLV-1:0]     r_slv_ce,   w_slv_ce_nxt;
    logic                r_slv_wr,   w_slv_wr_nxt;
    logic [AW-1:0]       r_slv_addr, w_slv_addr_nxt;
    logic [DW-1:0]       r_slv_wdat, w_slv_wdat_nxt;

    logic                w_start;
    logic [SELW-1:0]     w_sel_in;
    logic                w_miss;
    logic                w_rdy_sel;
    logic [DW-1:0]       w_rdat_sel;

    assign w_start  = r_pce_s_prev & ~r_pce_s;
    assign w_sel_in = i_paddr[SELW+AW-1:AW];
    // extra bit so NSLV == 2^SELW compares correctly
    assign w_miss   = ({1'b0, w_sel_in} >= (SELW+1)'(NSLV));

    // only the selected slave's ready/data is ever looked at
    always_comb begin
        w_rdy_sel  = 1'b0;
        w_rdat_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel == SELW'(i)) begin
                w_rdy_sel  = i_slv_rdy[i];
                w_rdat_sel = i_slv_rdat[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pce_meta   <= 1'b1;
            r_pce_s      <= 1'b1;
            r_pce_s_prev <= 1'b1;
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_timer      <= '0;
            r_prdy       <= 1'b0;
            r_perr       <= 1'b0;
            r_pdo        <= '0;
            r_slv_ce     <= '0;
            r_slv_wr     <= 1'b0;
            r_slv_addr   <= '0;
            r_slv_wdat   <= '0;
        end else begin
            r_pce_meta   <= i_pce_;
            r_pce_s      <= r_pce_meta;
            r_pce_s_prev <= r_pce_s;
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_timer      <= w_timer_nxt;
            r_prdy       <= w_prdy_nxt;
            r_perr       <= w_perr_nxt;
            r_pdo        <= w_pdo_nxt;
            r_slv_ce     <= w_slv_ce_nxt;
            r_slv_wr     <= w_slv_wr_nxt;
            r_slv_addr   <= w_slv_addr_nxt;
            r_slv_wdat   <= w_slv_wdat_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_timer_nxt    = r_timer;
        w_prdy_nxt     = r_prdy;
        w_perr_nxt     = r_perr;
        w_pdo_nxt      = r_pdo;
        w_slv_ce_nxt   = r_slv_ce;
        w_slv_wr_nxt   = r_slv_wr;
        w_slv_addr_nxt = r_slv_addr;
        w_slv_wdat_nxt = r_slv_wdat;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_sel_nxt = w_sel_in;
                    if (w_miss) begin
                        w_prdy_nxt  = 1'b1;
                        w_perr_nxt  = 1'b1;
                        w_pdo_nxt   = '1;
                        w_state_nxt = S_DONE;
                    end else begin
                        for (int i = 0; i < NSLV; i++) begin
                            w_slv_ce_nxt[i] = (w_sel_in == SELW'(i));
                        end
                        w_slv_wr_nxt   = i_pwr;
                        w_slv_addr_nxt = i_paddr[AW-1:0];
                        w_slv_wdat_nxt = i_pdi;
                        w_timer_nxt    = '0;
                        w_state_nxt    = S_ACC;
                    end
                end
            end

            S_ACC: begin
                if (r_pce_s) begin
                    // CPU withdrew the access: drop the slave quietly, no ready
                    w_slv_ce_nxt = '0;
                    w_slv_wr_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (w_rdy_sel) begin
                    if (!r_slv_wr) begin
                        w_pdo_nxt = w_rdat_sel;
                    end
                    w_prdy_nxt   = 1'b1;
                    w_perr_nxt   = 1'b0;
                    w_slv_ce_nxt = '0;
                    w_slv_wr_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end else if (r_timer == TOW'(TOMAX)) begin
                    if (!r_slv_wr) begin
                        w_pdo_nxt = '1;
                    end
                    w_prdy_nxt   = 1'b1;
                    w_perr_nxt   = 1'b1;
                    w_slv_ce_nxt = '0;
                    w_slv_wr_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_timer_nxt = r_timer + TOW'(1);
                end
            end

            S_DONE: begin
                if (r_pce_s) begin
                    w_prdy_nxt  = 1'b0;
                    w_perr_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_pdo      = r_pdo;
    assign o_prdy     = r_prdy;
    assign o_perr     = r_perr;
    assign o_slv_ce   = r_slv_ce;
    assign o_slv_wr   = r_slv_wr;
    assign o_slv_addr = r_slv_addr;
    assign o_slv_wdat = r_slv_wdat;

endmodule

// File: tb/tb_cpu_acc_ctrl.sv
`timescale 1ns/1ps
// Purpose : exercise cpu_acc_ctrl against a cycle-count reference model of the CPU access protocol.
// Latency : model expects slv_ce at edge 3, prdy at edge 3+len, prdy drop 3 edges after pce_ rises.
// Backpr. : slaves are modelled with a programmable wait count; pce_ is held low until prdy is seen.
module tb_cpu_acc_ctrl;

    localparam int TOMAX = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        pce_;
    logic        pwr;
    logic [9:0]  paddr;
    logic [15:0] pdi;

    logic [15:0] pdo;
    logic        prdy, perr, slv_wr;
    logic [3:0]  slv_ce;
    logic [7:0]  slv_addr;
    logic [15:0] slv_wdat;
    logic [63:0] slv_rdat;
    logic [3:0]  slv_rdy;

    // second instance with only 3 slaves, used for decode-miss coverage
    logic [15:0] pdo3;
    logic        prdy3, perr3, slv_wr3;
    logic [2:0]  slv_ce3;
    logic [7:0]  slv_addr3;
    logic [15:0] slv_wdat3;
    logic [47:0] slv_rdat3 = 48'h0;
    logic [2:0]  slv_rdy3  = 3'b111;

    int          wait_cyc [4];
    int          cnt      [4];
    logic [3:0]  noise;
    logic [15:0] pdo_model;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_acc_ctrl #(.NSLV(4), .SELW(2), .AW(8), .DW(16), .TOW(8), .TOMAX(TOMAX)) dut (
        .i_clk(clk), .i_rst(rst), .i_pce_(pce_), .i_pwr(pwr), .i_paddr(paddr), .i_pdi(pdi),
        .o_pdo(pdo), .o_prdy(prdy), .o_perr(perr), .o_slv_ce(slv_ce), .o_slv_wr(slv_wr),
        .o_slv_addr(slv_addr), .o_slv_wdat(slv_wdat), .i_slv_rdat(slv_rdat), .i_slv_rdy(slv_rdy)
    );

    cpu_acc_ctrl #(.NSLV(3), .SELW(2), .AW(8), .DW(16), .TOW(8), .TOMAX(TOMAX)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_pce_(pce_), .i_pwr(pwr), .i_paddr(paddr), .i_pdi(pdi),
        .o_pdo(pdo3), .o_prdy(prdy3), .o_perr(perr3), .o_slv_ce(slv_ce3), .o_slv_wr(slv_wr3),
        .o_slv_addr(slv_addr3), .o_slv_wdat(slv_wdat3), .i_slv_rdat(slv_rdat3), .i_slv_rdy(slv_rdy3)
    );

    // slave model: ready once its chip enable has been high for wait_cyc cycles;
    // noise drives ready on slaves that are not being accessed
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) cnt[i] <= slv_ce[i] ? cnt[i] + 1 : 0;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) slv_rdy[i] = (slv_ce[i] && (cnt[i] >= wait_cyc[i])) || noise[i];
    end

    // one full CPU access on the 4-slave instance, checked against the protocol model
    task automatic run_access(input logic [9:0] a, input logic w, input logic [15:0] d,
                              input int wt, input logic [15:0] rd);
        int          sel, len, ce_first, ce_cnt, prdy_first, drop;
        logic        err, bad_ce;
        logic [15:0] exp_pdo;
        sel = int'(a[9:8]);
        wait_cyc[sel]         = wt;
        slv_rdat[sel*16 +: 16] = rd;
        noise   = 4'($urandom) & ~(4'b0001 << sel);
        err     = (wt > TOMAX);
        len     = err ? TOMAX + 1 : wt + 1;
        exp_pdo = w ? pdo_model : (err ? 16'hFFFF : rd);

        @(negedge clk);
        paddr = a; pwr = w; pdi = d; pce_ = 1'b0;
        ce_first = -1; ce_cnt = 0; prdy_first = -1; bad_ce = 1'b0;
        for (int e = 1; e <= 400 && prdy_first < 0; e++) begin
            @(negedge clk);
            if (slv_ce != 4'b0) begin
                if (ce_first < 0) ce_first = e;
                ce_cnt++;
                if (slv_ce !== (4'b0001 << sel) || slv_wr !== w ||
                    slv_addr !== a[7:0] || slv_wdat !== d) bad_ce = 1'b1;
            end
            if (prdy === 1'b1) prdy_first = e;
        end
        checks++; if (ce_first != 3) begin failures++;
            $display("FAIL ce_latency a=%h got=%0d exp=3", a, ce_first); end
        checks++; if (ce_cnt != len) begin failures++;
            $display("FAIL ce_width a=%h got=%0d exp=%0d", a, ce_cnt, len); end
        checks++; if (bad_ce) begin failures++;
            $display("FAIL ce_fields a=%h slave outputs wrong while ce high", a); end
        checks++; if (prdy_first != 3 + len) begin failures++;
            $display("FAIL prdy_latency a=%h got=%0d exp=%0d", a, prdy_first, 3 + len); end
        checks++; if (perr !== err || pdo !== exp_pdo) begin failures++;
            $display("FAIL result a=%h perr=%b pdo=%h exp perr=%b pdo=%h", a, perr, pdo, err, exp_pdo); end
        checks++; if (slv_ce !== 4'b0 || slv_wr !== 1'b0) begin failures++;
            $display("FAIL ce_release a=%h ce=%b wr=%b exp 0", a, slv_ce, slv_wr); end

        repeat (3) @(negedge clk);
        checks++; if (prdy !== 1'b1 || perr !== err || pdo !== exp_pdo) begin failures++;
            $display("FAIL hold a=%h prdy=%b perr=%b pdo=%h exp 1/%b/%h", a, prdy, perr, pdo, err, exp_pdo); end

        pce_ = 1'b1;
        drop = -1;
        for (int e = 1; e <= 10 && drop < 0; e++) begin
            @(negedge clk);
            if (prdy === 1'b0) drop = e;
        end
        checks++; if (drop != 3) begin failures++;
            $display("FAIL prdy_release a=%h got=%0d exp=3", a, drop); end
        checks++; if (perr !== 1'b0 || pdo !== exp_pdo) begin failures++;
            $display("FAIL after_release a=%h perr=%b pdo=%h exp 0/%h", a, perr, pdo, exp_pdo); end
        pdo_model = exp_pdo;
        noise = 4'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pce_ = 1'b1; pwr = 1'b0; paddr = '0; pdi = '0; noise = 4'b0;
        slv_rdat = '0;
        for (int i = 0; i < 4; i++) wait_cyc[i] = 0;
        repeat (3) @(negedge clk);
        checks++; if (prdy !== 1'b0 || perr !== 1'b0 || pdo !== 16'h0) begin failures++;
            $display("FAIL reset_cpu prdy=%b perr=%b pdo=%h exp 0", prdy, perr, pdo); end
        checks++; if (slv_ce !== 4'b0 || slv_wr !== 1'b0 || slv_addr !== 8'h0 || slv_wdat !== 16'h0) begin failures++;
            $display("FAIL reset_slv ce=%b wr=%b addr=%h wdat=%h exp 0", slv_ce, slv_wr, slv_addr, slv_wdat); end
        rst = 1'b0;
        pdo_model = 16'h0;
        repeat (3) @(negedge clk);
        checks++; if (slv_ce !== 4'b0 || prdy !== 1'b0) begin failures++;
            $display("FAIL idle_after_reset ce=%b prdy=%b exp 0", slv_ce, prdy); end
    endtask

    task automatic test_read_zero_wait();
        run_access(10'h1A5, 1'b0, 16'h0000, 0, 16'h1234);
    endtask

    task automatic test_write_wait();
        run_access(10'h310, 1'b1, 16'hBEEF, 5, 16'h5555);
    endtask

    task automatic test_timeout();
        run_access(10'h2C3, 1'b0, 16'h0, 1000, 16'h4321);
    endtask

    task automatic test_decode_miss();
        int   prdy_first;
        logic ce_seen;
        wait_cyc[3] = 0; noise = 4'b0;
        @(negedge clk);
        paddr = 10'h3C4; pwr = 1'b1; pdi = 16'hA5A5; pce_ = 1'b0;
        prdy_first = -1; ce_seen = 1'b0;
        for (int e = 1; e <= 10 && prdy_first < 0; e++) begin
            @(negedge clk);
            if (slv_ce3 !== 3'b0) ce_seen = 1'b1;
            if (prdy3 === 1'b1) prdy_first = e;
        end
        checks++; if (prdy_first != 3) begin failures++;
            $display("FAIL miss_latency got=%0d exp=3", prdy_first); end
        checks++; if (ce_seen) begin failures++;
            $display("FAIL miss_ce ce pulsed on decode miss exp none"); end
        checks++; if (perr3 !== 1'b1 || pdo3 !== 16'hFFFF) begin failures++;
            $display("FAIL miss_result perr=%b pdo=%h exp 1/ffff", perr3, pdo3); end
        repeat (3) @(negedge clk);
        pce_ = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (prdy3 !== 1'b0 || perr3 !== 1'b0 || prdy !== 1'b0) begin failures++;
            $display("FAIL miss_release prdy3=%b perr3=%b prdy=%b exp 0", prdy3, perr3, prdy); end
    endtask

    task automatic test_abort();
        int   hi, extra;
        logic prdy_seen;
        wait_cyc[0] = 1000; noise = 4'b0;
        @(negedge clk);
        paddr = 10'h077; pwr = 1'b0; pce_ = 1'b0;
        hi = 0;
        for (int e = 1; e <= 20 && hi < 3; e++) begin
            @(negedge clk);
            if (slv_ce[0] === 1'b1) hi++;
        end
        pce_ = 1'b1;
        extra = 0; prdy_seen = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (slv_ce[0] === 1'b1) extra++;
            if (prdy !== 1'b0) prdy_seen = 1'b1;
        end
        checks++; if (hi != 3 || extra != 2) begin failures++;
            $display("FAIL abort_ce before=%0d after=%0d exp 3/2", hi, extra); end
        checks++; if (prdy_seen || slv_ce !== 4'b0 || pdo !== pdo_model) begin failures++;
            $display("FAIL abort_outputs prdy_seen=%b ce=%b pdo=%h exp 0/0/%h", prdy_seen, slv_ce, pdo, pdo_model); end
        run_access(10'h012, 1'b0, 16'h0, 2, 16'h0F0F);
    endtask

    task automatic test_reset_mid();
        int hi;
        wait_cyc[1] = 1000; noise = 4'b0;
        @(negedge clk);
        paddr = 10'h1E0; pwr = 1'b1; pdi = 16'h1357; pce_ = 1'b0;
        hi = 0;
        for (int e = 1; e <= 20 && hi < 3; e++) begin
            @(negedge clk);
            if (slv_ce[1] === 1'b1) hi++;
        end
        checks++; if (hi != 3) begin failures++;
            $display("FAIL rstmid_setup ce1 cycles=%0d exp 3", hi); end
        rst = 1'b1; pce_ = 1'b1;
        #1;
        checks++; if (slv_ce !== 4'b0 || slv_wr !== 1'b0 || slv_addr !== 8'h0 || slv_wdat !== 16'h0 ||
                      prdy !== 1'b0 || perr !== 1'b0 || pdo !== 16'h0) begin failures++;
            $display("FAIL rstmid_async ce=%b wr=%b addr=%h wdat=%h prdy=%b perr=%b pdo=%h exp 0",
                     slv_ce, slv_wr, slv_addr, slv_wdat, prdy, perr, pdo); end
        pdo_model = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (slv_ce !== 4'b0 || prdy !== 1'b0) begin failures++;
            $display("FAIL rstmid_idle ce=%b prdy=%b exp 0", slv_ce, prdy); end
        run_access(10'h155, 1'b0, 16'h0, 1, 16'hC0DE);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            logic [9:0]  a;
            logic        w;
            int          wt;
            a  = 10'($urandom);
            w  = 1'($urandom);
            wt = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 7));
            run_access(a, w, 16'($urandom), wt, 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_decode_miss();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
